// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment display path: digit geometry, saturation word, feeder FSM states.
// Pure declarations, no timing; no flow control.
// Imported by bin2bcd_feeder and bcd_dabble_step.
package ssd_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam logic [DIGIT_W*NUM_DIGITS-1:0] BCD_SAT = 16'h9999;

    // One guard digit above the displayed four catches samples above 9999.
    localparam int BCD_W = DIGIT_W * (NUM_DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } feeder_state_t;

    function automatic logic [DIGIT_W-1:0] dabble_adj(input logic [DIGIT_W-1:0] d);
        return (d >= DIGIT_W'(5)) ? d + DIGIT_W'(3) : d;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add-3 to every digit >= 5, then shift left pulling in the next binary bit.
// Combinational, zero latency.
// No flow control; the feeder FSM decides when the result is registered.
module bcd_dabble_step
    import ssd_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_in,
    input  logic             bit_in,
    output logic [BCD_W-1:0] bcd_out
);

    logic [BCD_W-1:0] adj;

    always_comb begin
        adj = '0;
        for (int i = 0; i < NUM_DIGITS + 1; i++) begin
            adj[i*DIGIT_W +: DIGIT_W] = dabble_adj(bcd_in[i*DIGIT_W +: DIGIT_W]);
        end
    end

    assign bcd_out = {adj[BCD_W-2:0], bit_in};

endmodule

// File: rtl/bin2bcd_feeder.sv
// Serial binary-to-BCD converter feeding the 4-digit seven-segment scanner; build option BCD_OVF_RAW_HEX_EN shows raw hex on overflow.
// Latency: sample accepted at edge k -> value/done/activate at edge k+IN_W+1; one sample per IN_W+2 cycles.
// Backpressure: in_ready is high only in IDLE; offered samples wait while a conversion is in flight.
module bin2bcd_feeder
    import ssd_pkg::*;
#(
    parameter int IN_W        = 16,
    parameter int STALE_LIMIT = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [IN_W-1:0]               in_data,
    output logic                          in_ready,
    output logic [DIGIT_W*NUM_DIGITS-1:0] value,
    output logic                          activate,
    output logic                          done,
    output logic                          overflow
);

    localparam int CNT_W = $clog2(IN_W);
    localparam int VAL_W = DIGIT_W * NUM_DIGITS;

    feeder_state_t    state, state_nxt;
    logic [BCD_W-1:0] bcd_acc;
    logic [BCD_W-1:0] bcd_step;
    logic [IN_W-1:0]  bin_sr;
    logic [CNT_W-1:0] bit_cnt;
    logic             accept;
    logic             ovf_nxt;
    logic [VAL_W-1:0] ovf_value;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---------------- Datapath ----------------
    bcd_dabble_step u_step (
        .bcd_in  (bcd_acc),
        .bit_in  (bin_sr[IN_W-1]),
        .bcd_out (bcd_step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_acc <= '0;
            bin_sr  <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            bcd_acc <= '0;
            bin_sr  <= in_data;
            bit_cnt <= CNT_W'(IN_W - 1);
        end else if (state == SHIFT) begin
            bcd_acc <= bcd_step;
            bin_sr  <= {bin_sr[IN_W-2:0], 1'b0};
            bit_cnt <= bit_cnt - 1'b1;
        end
    end

    assign ovf_nxt = |bcd_acc[BCD_W-1:VAL_W];

`ifdef BCD_OVF_RAW_HEX_EN
    // The shift register is drained by the end of conversion, so keep the raw sample aside.
    logic [IN_W-1:0] raw_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raw_q <= '0;
        end else if (accept) begin
            raw_q <= in_data;
        end
    end

    assign ovf_value = VAL_W'(raw_q);
`else
    assign ovf_value = BCD_SAT;
`endif

    // ---------------- Outputs ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value    <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (state == DONE) begin
                overflow <= ovf_nxt;
                value    <= ovf_nxt ? ovf_value : bcd_acc[VAL_W-1:0];
            end
        end
    end

    generate
        if (STALE_LIMIT == 0) begin : g_no_stale
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    activate <= 1'b0;
                end else if (state == DONE) begin
                    activate <= 1'b1;
                end
            end
        end else begin : g_stale
            localparam int STALE_W = $clog2(STALE_LIMIT + 1);
            localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_LIMIT);

            logic [STALE_W-1:0] stale_cnt;

            // activate falls on the same edge the counter lands on the limit.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stale_cnt <= '0;
                    activate  <= 1'b0;
                end else if (state == DONE) begin
                    stale_cnt <= '0;
                    activate  <= 1'b1;
                end else if (stale_cnt != STALE_MAX) begin
                    stale_cnt <= stale_cnt + 1'b1;
                    if (stale_cnt == STALE_MAX - 1'b1) begin
                        activate <= 1'b0;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_bin2bcd_feeder.sv
// Scoreboard bench for bin2bcd_feeder: two instances (no stale timer, STALE_LIMIT=8) share one input stream.
module tb_bin2bcd_feeder;

`ifdef BCD_OVF_RAW_HEX_EN
    localparam bit RAW = 1'b1;
`else
    localparam bit RAW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;

    logic        rdy0, rdy8;
    logic [15:0] val0, val8;
    logic        act0, act8, done0, done8, ovf0, ovf8;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] val;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic prev_done0 = 1'b0;

    bin2bcd_feeder #(.IN_W(16), .STALE_LIMIT(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .value(val0), .activate(act0), .done(done0), .overflow(ovf0)
    );

    bin2bcd_feeder #(.IN_W(16), .STALE_LIMIT(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy8), .value(val8), .activate(act8), .done(done8), .overflow(ovf8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (!reset && done0) begin
            if (prev_done0) begin
                checks++;
                errors++;
                $display("FAIL done_pulse: done high two cycles in a row at cycle %0d", cyc);
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: done with no sample pending at cycle %0d, value %h", cyc, val0);
            end else begin
                mon_e = sb.pop_front();
                check("value",     32'(val0), 32'(mon_e.val));
                check("overflow",  32'(ovf0), 32'(mon_e.ovf));
                check("activate",  32'(act0), 32'd1);
                check("latency",   32'(cyc),  32'(mon_e.due));
                check("value_s8",  32'(val8), 32'(mon_e.val));
                check("ovf_s8",    32'(ovf8), 32'(mon_e.ovf));
                check("done_s8",   32'(done8), 32'd1);
                check("act_s8",    32'(act8), 32'd1);
            end
        end
        prev_done0 <= done0;
    end

    // Offer a sample and hold it until accepted; reports how many cycles ready was low.
    task automatic send(input logic [15:0] d, input logic [15:0] exp_bcd, input logic exp_ovf,
                        output int waited);
        exp_t e;
        waited   = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!rdy0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!rdy0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, needed 1", waited);
        end else begin
            e.val = exp_ovf ? (RAW ? d : 16'h9999) : exp_bcd;
            e.ovf = exp_ovf;
            e.due = cyc + 1 + 17;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done0) begin
            checks++;
            errors++;
            $display("FAIL wait_done: done stayed 0 for %0d cycles, needed 1", n);
        end
    endtask

    initial begin
        int w;
        int w2;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        #1;
        check("rst_value",    32'(val0), 32'h0);
        check("rst_activate", 32'(act0), 32'd0);
        check("rst_done",     32'(done0), 32'd0);
        check("rst_overflow", 32'(ovf0), 32'd0);
        check("rst_ready",    32'(rdy0), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_activate", 32'(act0), 32'd0);

        send(16'd1234, 16'h1234, 1'b0, w);
        wait_done();
        repeat (3) @(negedge clk);
        check("hold_value", 32'(val0), 32'h1234);
        check("hold_done",  32'(done0), 32'd0);

        send(16'd9999,  16'h9999, 1'b0, w); wait_done(); @(negedge clk);
        send(16'd10000, 16'h0000, 1'b1, w); wait_done(); @(negedge clk);
        send(16'd65535, 16'h0000, 1'b1, w); wait_done(); @(negedge clk);
        send(16'd8000,  16'h8000, 1'b0, w); wait_done(); @(negedge clk);
        send(16'd1,     16'h0001, 1'b0, w); wait_done(); @(negedge clk);

        // Back-to-back: valid never drops between the two samples.
        send(16'd0, 16'h0000, 1'b0, w);
        send(16'd7, 16'h0007, 1'b0, w2);
        check("ready_low_cycles", 32'(w2), 32'd17);
        wait_done();
        @(negedge clk);

        // Stale timer on dut8; dut0 never drops activate.
        send(16'd42, 16'h0042, 1'b0, w);
        wait_done();
        for (int j = 0; j < 12; j++) begin
            check($sformatf("stale_act_%0d", j), 32'(act8), (j < 8) ? 32'd1 : 32'd0);
            check($sformatf("stale_val_%0d", j), 32'(val8), 32'h0042);
            @(negedge clk);
        end
        check("nostale_act", 32'(act0), 32'd1);
        send(16'd5, 16'h0005, 1'b0, w);
        wait_done();
        @(negedge clk);
        check("reassert_act_s8", 32'(act8), 32'd1);

        // Reset in the middle of a conversion.
        send(16'd4321, 16'h4321, 1'b0, w);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        void'(sb.pop_back());
        #1;
        check("midrst_value",    32'(val0), 32'h0);
        check("midrst_activate", 32'(act0), 32'd0);
        check("midrst_overflow", 32'(ovf0), 32'd0);
        check("midrst_done",     32'(done0), 32'd0);
        check("midrst_ready",    32'(rdy0), 32'd1);
        check("midrst_act_s8",   32'(act8), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check("postrst_value", 32'(val0), 32'h0);
        send(16'd4321, 16'h4321, 1'b0, w);
        wait_done();
        repeat (2) @(negedge clk);

        check("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
